// File: rtl/epp_master.sv
// EPP host (initiator) for exercising a board-side EPP slave port.
// A single-outstanding command port drives address/data read and write
// cycles: direction and write data are set up first, then ASTB or DSTB is
// strobed low, with a full WAIT handshake in both directions. Every wait
// for a WAIT edge is bounded by a saturating timeout counter.
module epp_master #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       CLK_IN,
    input  logic       RST_ASYNC_IN,
    input  logic       CMD_REQ_IN,
    input  logic [1:0] CMD_TYPE_IN,
    input  logic [7:0] CMD_WDATA_IN,
    output logic       CMD_ACK_OUT,
    output logic       RSP_VALID_OUT,
    output logic [7:0] RSP_RDATA_OUT,
    output logic       RSP_TIMEOUT_OUT,
    output logic       EPP_ASTB_OUT,
    output logic       EPP_DSTB_OUT,
    output logic       EPP_WRITE_OUT,
    output logic [7:0] EPP_DATA_OUT,
    output logic       EPP_DATA_OE_OUT,
    input  logic [7:0] EPP_DATA_IN,
    input  logic       EPP_WAIT_IN
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    localparam logic [15:0] SETUP_LIM = 16'(SETUP_CYCLES);
    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Two-stage WAIT synchroniser; only wait_s is used by the FSM.
    logic       wait_p0;
    logic       wait_p1;
    logic       wait_s;

    state_t     state;
    state_t     state_nxt;
    logic [15:0] cnt;
    logic [1:0] cmd_type;
    logic [1:0] cmd_type_nxt;
    logic       accept;
    logic       abort;

    // Values the registered outputs take on the next edge.
    logic       in_cycle;
    logic       strobe_on;
    logic       astb_d;
    logic       dstb_d;
    logic       write_d;
    logic       oe_d;

    assign wait_s = wait_p1;

    // Synchronise the slave's WAIT into the clock domain.
    always_ff @(posedge CLK_IN or posedge RST_ASYNC_IN) begin
        if (RST_ASYNC_IN) begin
            wait_p0 <= 1'b0;
            wait_p1 <= 1'b0;
        end else begin
            wait_p0 <= EPP_WAIT_IN;
            wait_p1 <= wait_p0;
        end
    end

    // State register, latched command type and per-state saturating counter.
    always_ff @(posedge CLK_IN or posedge RST_ASYNC_IN) begin
        if (RST_ASYNC_IN) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cmd_type <= 2'b00;
        end else begin
            state    <= state_nxt;
            cmd_type <= cmd_type_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Next-state logic: setup delay, WAIT handshake and timeout aborts.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (CMD_REQ_IN) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!wait_s) begin
                    if (cnt >= SETUP_LIM) begin
                        state_nxt = ST_STROBE;
                    end
                end else if (cnt >= TO_LIM) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_STROBE: begin
                if (wait_s) begin
                    state_nxt = ST_HOLD;
                end else if (cnt >= TO_LIM) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_HOLD: begin
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!wait_s) begin
                    state_nxt = ST_DONE;
                end else if (cnt >= TO_LIM) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so pins line up with the state.
    always_comb begin
        cmd_type_nxt = accept ? CMD_TYPE_IN : cmd_type;
        in_cycle     = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                       (state_nxt == ST_HOLD)  || (state_nxt == ST_RELEASE);
        strobe_on    = (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);
        astb_d       = !(strobe_on && !cmd_type_nxt[1]);
        dstb_d       = !(strobe_on && cmd_type_nxt[1]);
        write_d      = in_cycle ? cmd_type_nxt[0] : 1'b1;
        oe_d         = in_cycle && !cmd_type_nxt[0];
    end

    // Registered outputs; read data is captured at the end of HOLD only.
    always_ff @(posedge CLK_IN or posedge RST_ASYNC_IN) begin
        if (RST_ASYNC_IN) begin
            EPP_ASTB_OUT    <= 1'b1;
            EPP_DSTB_OUT    <= 1'b1;
            EPP_WRITE_OUT   <= 1'b1;
            EPP_DATA_OUT    <= 8'h00;
            EPP_DATA_OE_OUT <= 1'b0;
            CMD_ACK_OUT     <= 1'b0;
            RSP_VALID_OUT   <= 1'b0;
            RSP_RDATA_OUT   <= 8'h00;
            RSP_TIMEOUT_OUT <= 1'b0;
        end else begin
            EPP_ASTB_OUT    <= astb_d;
            EPP_DSTB_OUT    <= dstb_d;
            EPP_WRITE_OUT   <= write_d;
            EPP_DATA_OE_OUT <= oe_d;
            CMD_ACK_OUT     <= accept;
            RSP_VALID_OUT   <= (state_nxt == ST_DONE);
            RSP_TIMEOUT_OUT <= abort;
            if (accept) begin
                EPP_DATA_OUT <= CMD_WDATA_IN;
            end
            if ((state == ST_HOLD) && cmd_type[0]) begin
                RSP_RDATA_OUT <= EPP_DATA_IN;
            end
        end
    end

endmodule
